// File: rtl/if_id_skid_buffer.sv
// IF/ID decoupling FIFO: buffers fetched instructions for decode.
// Decode stalls back-pressure fetch through ReadyF, and FlushD discards all entries.
module if_id_skid_buffer #(
    parameter int          W     = 32,
    parameter int          DEPTH = 2,
    parameter logic [W-1:0] NOP  = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               InstrF,
    input  logic [W-1:0]               PCF,
    input  logic [W-1:0]               PCPlus4F,
    input  logic                       ValidF,
    output logic                       ReadyF,
    output logic [W-1:0]               InstrD,
    output logic [W-1:0]               PCD,
    output logic [W-1:0]               PCPlus4D,
    output logic                       ValidD,
    input  logic                       StallD,
    input  logic                       FlushD,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [W-1:0] instr;
        logic [W-1:0] pc;
        logic [W-1:0] pc4;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          enq;
    logic          deq;
    entry_t        head;

    assign ReadyF = (cnt < CW'(DEPTH)) & ~rst;
    assign ValidD = (cnt != '0);
    assign enq    = ValidF & ReadyF & ~FlushD;
    assign deq    = ValidD & ~StallD & ~FlushD;
    assign Count  = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (FlushD) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= '{instr: InstrF, pc: PCF, pc4: PCPlus4F};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (enq && !deq) begin
                cnt <= cnt + CW'(1);
            end else if (deq && !enq) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Empty buffer presents a bubble rather than stale storage.
    always_comb begin
        head = mem[rd_ptr];
        if (!ValidD) begin
            head = '{instr: NOP, pc: '0, pc4: '0};
        end
    end

    assign InstrD   = head.instr;
    assign PCD      = head.pc;
    assign PCPlus4D = head.pc4;

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for if_id_skid_buffer (DEPTH=2).
// Covers reset, streaming, back-pressure, flush and pointer wrap.
module tb_if_id_skid_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ValidF;
    logic        ReadyF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        StallD;
    logic        FlushD;
    logic [1:0]  Count;

    int n_chk;
    int n_fail;

    if_id_skid_buffer #(.W(32), .DEPTH(2), .NOP(NOP)) dut (
        .clk(clk), .rst(rst),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .ValidF(ValidF), .ReadyF(ReadyF),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .StallD(StallD), .FlushD(FlushD),
        .Count(Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        ValidF   = v;
        PCF      = pc;
        PCPlus4F = pc + 32'd4;
        InstrF   = 32'h00000093 | (pc << 18);
    endtask

    initial begin
        int sent, rcv, mcnt, cyc;
        logic e, d;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        chk("rst_ready", 32'(ReadyF), 32'd0);
        tick();
        #3 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(ValidD), 32'd0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_pcd", PCD, 32'd0);
        chk("rst_ready1", 32'(ReadyF), 32'd1);
        tick();

        // streaming
        ValidF = 1'b1; PCF = 32'h0; PCPlus4F = 32'h4; InstrF = 32'h00A00093;
        tick();
        chk("str0_instr", InstrD, 32'h00A00093);
        chk("str0_pc", PCD, 32'h0);
        chk("str0_pc4", PCPlus4D, 32'h4);
        chk("str0_cnt", 32'(Count), 32'd1);
        PCF = 32'h4; PCPlus4F = 32'h8; InstrF = 32'h00B00113;
        tick();
        chk("str1_instr", InstrD, 32'h00B00113);
        chk("str1_pc", PCD, 32'h4);
        chk("str1_cnt", 32'(Count), 32'd1);
        PCF = 32'h8; PCPlus4F = 32'hC; InstrF = 32'h00C00193;
        tick();
        chk("str2_instr", InstrD, 32'h00C00193);
        chk("str2_pc", PCD, 32'h8);
        chk("str2_valid", 32'(ValidD), 32'd1);
        ValidF = 1'b0;
        tick();
        chk("str_drain_valid", 32'(ValidD), 32'd0);
        chk("str_drain_instr", InstrD, NOP);

        // back-pressure and full with simultaneous dequeue
        StallD = 1'b1;
        drive(1'b1, 32'h0);
        tick();
        chk("bp_cnt1", 32'(Count), 32'd1);
        drive(1'b1, 32'h4);
        tick();
        chk("bp_cnt2", 32'(Count), 32'd2);
        chk("bp_ready", 32'(ReadyF), 32'd0);
        drive(1'b1, 32'h8);
        tick();
        chk("bp_hold_cnt", 32'(Count), 32'd2);
        chk("bp_hold_pc", PCD, 32'h0);
        StallD = 1'b0;
        tick();
        chk("full_deq_cnt", 32'(Count), 32'd1);
        chk("full_deq_ready", 32'(ReadyF), 32'd1);
        chk("bp_pc1", PCD, 32'h4);
        tick();
        chk("bp_pc2", PCD, 32'h8);
        chk("bp_pc2_cnt", 32'(Count), 32'd1);
        drive(1'b0, 32'h0);
        tick();
        chk("bp_empty", 32'(Count), 32'd0);

        // flush with stall and incoming fetch
        StallD = 1'b1;
        drive(1'b1, 32'h20);
        tick();
        drive(1'b1, 32'h24);
        tick();
        chk("fl_pre_cnt", 32'(Count), 32'd2);
        drive(1'b1, 32'h28);
        FlushD = 1'b1;
        tick();
        chk("fl_cnt", 32'(Count), 32'd0);
        chk("fl_valid", 32'(ValidD), 32'd0);
        chk("fl_instr", InstrD, NOP);
        FlushD = 1'b0;
        StallD = 1'b0;
        drive(1'b1, 32'h40);
        tick();
        chk("fl_new_pc", PCD, 32'h40);
        chk("fl_new_cnt", 32'(Count), 32'd1);
        drive(1'b0, 32'h0);
        tick();
        chk("fl_after_valid", 32'(ValidD), 32'd0);

        // wrap-around with alternating stalls
        sent = 0; rcv = 0; mcnt = 0; cyc = 0;
        while ((rcv < 10) && (cyc < 60)) begin
            drive(sent < 10, 32'h100 + 32'(4 * sent));
            StallD = cyc[0];
            chk("wrap_cnt", 32'(Count), 32'(mcnt));
            e = ValidF && (mcnt < 2);
            d = (mcnt != 0) && !StallD;
            if (d) chk("wrap_pc", PCD, 32'h100 + 32'(4 * rcv));
            tick();
            if (e) sent++;
            if (d) rcv++;
            mcnt = mcnt + int'(e) - int'(d);
            cyc++;
        end
        chk("wrap_rcv", 32'(rcv), 32'd10);
        drive(1'b0, 32'h0);
        StallD = 1'b0;
        tick();
        chk("wrap_empty", 32'(Count), 32'd0);

        // asynchronous reset mid-operation
        drive(1'b1, 32'h80);
        tick();
        drive(1'b0, 32'h0);
        chk("ar_pre_cnt", 32'(Count), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(ValidD), 32'd0);
        chk("ar_cnt", 32'(Count), 32'd0);
        chk("ar_instr", InstrD, NOP);
        chk("ar_ready", 32'(ReadyF), 32'd0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("ar_ready1", 32'(ReadyF), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Receiving end of the fetch-stage output interface (InstrF/PCF/PCPlus4F).
- Replaces a bare IF/ID register with a small FIFO that decouples fetch from decode.
- Decode-side stall back-pressures fetch through ReadyF.
- A taken branch/jump discards all buffered instructions through FlushD.

Parameters:
- W, 32: data width of instruction and PC fields.
- DEPTH, 2: number of buffered entries. Must be a power of 2, range 2..8.
- NOP, 32'h00000013: instruction presented on InstrD when the buffer is empty (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- InstrF  input  W  fetched instruction.
- PCF  input  W  PC of fetched instruction.
- PCPlus4F  input  W  PC+4 of fetched instruction.
- ValidF  input  1  fetch presents a valid instruction this cycle.
- ReadyF  output  1  buffer can accept an entry this cycle.
- InstrD  output  W  head-entry instruction to decode.
- PCD  output  W  head-entry PC.
- PCPlus4D  output  W  head-entry PC+4.
- ValidD  output  1  head entry is valid.
- StallD  input  1  decode cannot consume this cycle.
- FlushD  input  1  discard all entries (branch/jump redirect).
- Count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage:
  - DEPTH entries of {Instr, PC, PCPlus4}.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter Count, range 0..DEPTH.
- Reset (rst=1, asynchronous):
  - Pointers=0, Count=0, all storage=0.
  - Outputs: ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0.
  - ReadyF is forced 0 while rst is high; ReadyF=1 on the first cycle after rst deasserts.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- ReadyF = (Count < DEPTH) and not rst. It depends only on registered state, never on StallD, FlushD or ValidF.
- Enqueue: enq = ValidF & ReadyF & ~FlushD. On the clock edge, write the inputs at the write pointer and advance the write pointer.
- Dequeue: deq = ValidD & ~StallD & ~FlushD. On the clock edge, advance the read pointer.
- Count update: +1 on enq only, -1 on deq only, unchanged when both or neither occur.
- Outputs:
  - ValidD = (Count != 0).
  - InstrD/PCD/PCPlus4D are the head entry, read combinationally from registered storage.
  - When Count==0: InstrD=NOP, PCD=0, PCPlus4D=0.
- Latency: an entry enqueued at edge N is visible on the D outputs after edge N (1-cycle latency). There is no combinational pass-through from F to D.
- Full (Count==DEPTH):
  - ReadyF=0, so no enqueue occurs even if a dequeue happens the same cycle.
  - ReadyF rises the cycle after the dequeue.
- Empty (Count==0): ValidD=0, so no dequeue occurs and StallD is ignored.
- Simultaneous enq and deq with 0<Count<DEPTH: both pointers advance and Count is unchanged.
- FlushD=1:
  - Takes priority over enqueue and dequeue.
  - On the edge: pointers=0, Count=0, and the instruction presented this cycle is dropped.
  - ValidD=0 from the next cycle.
  - FlushD together with StallD: flush wins.
- Pointer wrap: after DEPTH enqueues the write pointer returns to 0. Order is preserved across the wrap.
- Entries are never overwritten while valid. Storage contents are not cleared by flush (don't-care once invalid).

Test Plan:
- Reset then idle: rst pulsed mid-cycle -> ValidD=0, InstrD=32'h00000013, Count=0 immediately; ReadyF=1 on the first cycle after rst falls.
- Streaming: ValidF=1 every cycle with InstrF=0x00A00093, 0x00B00113, 0x00C00193, PCF=0x0,0x4,0x8, StallD=0 -> the same values appear on InstrD/PCD one cycle later in order, Count stays 1, ValidD=1.
- Back-pressure: StallD=1, send 3 instructions (DEPTH=2) -> first two accepted, Count=2, ReadyF=0, third held by fetch; StallD drops -> PCD shows 0x0 then 0x4 then 0x8 in order.
- Full with simultaneous dequeue: Count=2, StallD=0, ValidF=1 -> no enqueue that cycle, Count=1, ReadyF=1 next cycle.
- Flush: Count=2 with StallD=1 and ValidF=1, assert FlushD for one cycle -> next cycle Count=0, ValidD=0, InstrD=NOP; the following ValidF instruction (PCF=0x40) appears at PCD with no stale entries.
- Wrap-around: 10 enqueue/dequeue pairs with alternating stalls -> the sequence of PCD values equals the sequence of PCF values exactly; no loss or duplication across pointer wrap.
